// File: rtl/scaler_line_packer_if.sv
// Pixel stream between the scaler and the line packer: sparse input side and packed output side.
interface scaler_line_packer_if #(
    parameter int PIXEL_WIDTH = 12
);
    logic [PIXEL_WIDTH-1:0] di_i;
    logic                   de_i;
    logic                   hs_i;
    logic                   vs_i;
    logic [PIXEL_WIDTH-1:0] do_o;
    logic                   de_o;
    logic                   hs_o;
    logic                   vs_o;

    modport master (output di_i, de_i, hs_i, vs_i, input  do_o, de_o, hs_o, vs_o);
    modport slave  (input  di_i, de_i, hs_i, vs_i, output do_o, de_o, hs_o, vs_o);
endinterface

// File: rtl/scaler_line_packer.sv
// Ping-pong two-line buffer: collects sparse scaler pixels and replays each line as a contiguous
// de burst framed by regular hs/vs pulses, with line length, line count and overflow status.
module scaler_line_packer #(
    parameter string VENDOR_RAM_STYLE  = "MLAB",
    parameter int    LINE_OUT_SIZE_MAX = 1024,
    parameter int    PIXEL_WIDTH       = 12,
    parameter int    HS_WIDTH          = 4,
    parameter int    GAP_WIDTH         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    scaler_line_packer_if.slave  vid,
    output logic [15:0]          line_len_o,
    output logic [15:0]          line_cnt_o,
    output logic                 ovf_o
);
    localparam int AW = $clog2(LINE_OUT_SIZE_MAX);
    localparam int CW = $clog2(LINE_OUT_SIZE_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_HS, S_ACT, S_GAP} state_t;

    (* ramstyle = VENDOR_RAM_STYLE *) logic [PIXEL_WIDTH-1:0] r_bank0 [LINE_OUT_SIZE_MAX];
    (* ramstyle = VENDOR_RAM_STYLE *) logic [PIXEL_WIDTH-1:0] r_bank1 [LINE_OUT_SIZE_MAX];
    logic [PIXEL_WIDTH-1:0] r_rd_data;

    logic          r_hs_q, r_hs_prev, r_vs_q, r_vs_prev;
    logic [CW-1:0] r_wr_cnt;
    logic          r_wr_bank, r_rd_bank, r_drop, r_sof_pend;
    logic [1:0]    r_full;
    logic [CW-1:0] r_len [2];
    logic [1:0]    r_tag;
    logic [15:0]   r_frm_cnt;
    state_t        r_state;
    logic [15:0]   r_cnt;

    logic          w_line_end, w_sof, w_bank_busy, w_wr_ok, w_px_drop, w_commit;
    logic [CW-1:0] w_wr_cnt_eff;
    state_t        w_state_nxt;
    logic [15:0]   w_cnt_nxt;
    logic [AW-1:0] w_rd_addr;
    logic          w_release;

    assign w_line_end   = r_hs_prev & ~r_hs_q;
    assign w_sof        = ~r_vs_prev & r_vs_q;
    // A line that lost a pixel to a full buffer is dropped entirely, even if a bank frees up mid-line.
    assign w_bank_busy  = r_full[r_wr_bank] | r_drop;
    assign w_wr_ok      = vid.de_i & ~w_bank_busy & (r_wr_cnt != CW'(LINE_OUT_SIZE_MAX));
    assign w_px_drop    = vid.de_i & ~w_wr_ok;
    assign w_wr_cnt_eff = r_wr_cnt + CW'(w_wr_ok);
    assign w_commit     = w_line_end & ~w_bank_busy & (w_wr_cnt_eff != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs_q     <= 1'b0;
            r_hs_prev  <= 1'b0;
            r_vs_q     <= 1'b0;
            r_vs_prev  <= 1'b0;
            r_wr_cnt   <= '0;
            r_wr_bank  <= 1'b0;
            r_drop     <= 1'b0;
            r_sof_pend <= 1'b0;
            r_full     <= '0;
            r_len[0]   <= '0;
            r_len[1]   <= '0;
            r_tag      <= '0;
            r_frm_cnt  <= '0;
            line_len_o <= '0;
            line_cnt_o <= '0;
            ovf_o      <= 1'b0;
        end else begin
            r_hs_q    <= vid.hs_i;
            r_hs_prev <= r_hs_q;
            r_vs_q    <= vid.vs_i;
            r_vs_prev <= r_vs_q;
            r_wr_cnt  <= w_line_end ? '0 : w_wr_cnt_eff;
            if (w_line_end) begin
                r_drop <= 1'b0;
            end else if (vid.de_i && r_full[r_wr_bank]) begin
                r_drop <= 1'b1;
            end
            if (w_commit) begin
                r_len[r_wr_bank]  <= w_wr_cnt_eff;
                r_tag[r_wr_bank]  <= r_sof_pend;
                r_full[r_wr_bank] <= 1'b1;
                r_wr_bank         <= ~r_wr_bank;
                line_len_o        <= 16'(w_wr_cnt_eff);
            end
            // Commit and release always address different banks, so both may land together.
            if (w_release) begin
                r_full[r_rd_bank] <= 1'b0;
            end
            if (w_sof) begin
                r_sof_pend <= 1'b1;
                r_frm_cnt  <= '0;
                line_cnt_o <= r_frm_cnt + 16'(w_commit);
            end else if (w_commit) begin
                r_sof_pend <= 1'b0;
                r_frm_cnt  <= r_frm_cnt + 16'd1;
            end
            if (w_px_drop || (w_line_end && r_drop)) begin
                ovf_o <= 1'b1;
            end else if (w_sof) begin
                ovf_o <= 1'b0;
            end
        end
    end

    // NOTE: line RAMs and their read register carry no reset so they map onto block/MLAB memory;
    // do_o is gated by de_o, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            if (r_wr_bank) begin
                r_bank1[r_wr_cnt[AW-1:0]] <= vid.di_i;
            end else begin
                r_bank0[r_wr_cnt[AW-1:0]] <= vid.di_i;
            end
        end
        r_rd_data <= r_rd_bank ? r_bank1[w_rd_addr] : r_bank0[w_rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rd_bank <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 16'd1;
        w_rd_addr   = '0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (r_full[r_rd_bank]) begin
                    w_state_nxt = S_HS;
                end
            end
            S_HS: begin
                if (r_cnt == 16'(HS_WIDTH - 1)) begin
                    w_state_nxt = S_ACT;
                    w_cnt_nxt   = '0;
                end
            end
            S_ACT: begin
                w_rd_addr = AW'(r_cnt + 16'd1);
                if (r_cnt == 16'(r_len[r_rd_bank]) - 16'd1) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                if (r_cnt == 16'(GAP_WIDTH - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_release   = 1'b1;
                end
            end
        endcase
    end

    assign vid.hs_o = (r_state == S_HS);
    assign vid.vs_o = (r_state == S_HS) & r_tag[r_rd_bank];
    assign vid.de_o = (r_state == S_ACT);
    assign vid.do_o = vid.de_o ? r_rd_data : '0;
endmodule
